// File: rtl/exception_ctrl.sv
// Exception/interrupt controller for the single-cycle LEGv8 core: redirects the PC on
// invalid opcodes, illegal ERET and external IRQs, and holds ELR/ESR and a saturating count.
module exception_ctrl #(
    parameter logic [63:0] EXC_VECTOR = 64'h0000_0000_0000_00D8,
    parameter int          CNT_W      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] PC,
    input  logic        NotAnInstr,
    input  logic        ERet,
    input  logic        ExtIRQ,
    input  logic [1:0]  SysRegSel,
    output logic        ExcTake,
    output logic [63:0] ExcPC,
    output logic        IrqAck,
    output logic        Halt,
    output logic [63:0] ELR,
    output logic [3:0]  ESR,
    output logic [63:0] SysRegData
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_HANDLER = 2'b01,
        ST_FAULT   = 2'b10
    } state_t;

    localparam logic [3:0] CAUSE_NONE  = 4'b0000;
    localparam logic [3:0] CAUSE_INSTR = 4'b0001;
    localparam logic [3:0] CAUSE_IRQ   = 4'b0010;
    localparam logic [3:0] CAUSE_ERET  = 4'b0011;

    state_t           state_q, state_d;
    logic [63:0]      elr_q, elr_d;
    logic [3:0]       esr_q, esr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sync_q, sync_d;

    logic        irq_s;
    logic [3:0]  cause;
    logic        exc_take;
    logic        irq_ack;
    logic [63:0] exc_pc;

    assign irq_s  = sync_q[1];
    assign sync_d = {sync_q[0], ExtIRQ};

    always_comb begin
        cause = CAUSE_NONE;
        if (NotAnInstr) begin
            cause = CAUSE_INSTR;
        end else if (ERet) begin
            cause = CAUSE_ERET;
        end else if (irq_s) begin
            cause = CAUSE_IRQ;
        end
    end

    always_comb begin
        state_d  = state_q;
        elr_d    = elr_q;
        esr_d    = esr_q;
        cnt_d    = cnt_q;
        exc_take = 1'b0;
        irq_ack  = 1'b0;
        exc_pc   = EXC_VECTOR;
        case (state_q)
            ST_RUN: begin
                if (cause != CAUSE_NONE) begin
                    exc_take = 1'b1;
                    irq_ack  = (cause == CAUSE_IRQ);
                    state_d  = ST_HANDLER;
                    elr_d    = PC;
                    esr_d    = cause;
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_HANDLER: begin
                // A bad opcode inside the handler is unrecoverable, even alongside ERET
                if (NotAnInstr) begin
                    state_d = ST_FAULT;
                    esr_d   = CAUSE_INSTR;
                end else if (ERet) begin
                    exc_take = 1'b1;
                    exc_pc   = elr_q;
                    state_d  = ST_RUN;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            elr_q   <= 64'd0;
            esr_q   <= 4'd0;
            cnt_q   <= '0;
            sync_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            elr_q   <= elr_d;
            esr_q   <= esr_d;
            cnt_q   <= cnt_d;
            sync_q  <= sync_d;
        end
    end

    // Redirects are gated by reset so a flagged instruction during reset has no effect
    assign ExcTake = exc_take & reset;
    assign IrqAck  = irq_ack & reset;
    assign ExcPC   = reset ? exc_pc : EXC_VECTOR;
    assign Halt    = (state_q == ST_FAULT);
    assign ELR     = elr_q;
    assign ESR     = esr_q;

    always_comb begin
        SysRegData = 64'd0;
        case (SysRegSel)
            2'b00:   SysRegData = elr_q;
            2'b01:   SysRegData = {60'd0, esr_q};
            2'b10:   SysRegData = {{(64-CNT_W){1'b0}}, cnt_q};
            default: SysRegData = {62'd0, state_q};
        endcase
    end

endmodule

// File: tb/tb_exception_ctrl.sv
// Self-checking bench for exception_ctrl: directed scenarios followed by random stimulus,
// all checked against a behavioural model of the exception rules.
module tb_exception_ctrl;

    localparam logic [63:0] VEC = 64'h0000_0000_0000_00D8;

    logic        clk;
    logic        reset;
    logic [63:0] PC;
    logic        NotAnInstr;
    logic        ERet;
    logic        ExtIRQ;
    logic [1:0]  SysRegSel;

    logic        ExcTake, IrqAck, Halt;
    logic [63:0] ExcPC, ELR, SysRegData;
    logic [3:0]  ESR;

    logic        s_ExcTake, s_IrqAck, s_Halt;
    logic [63:0] s_ExcPC, s_ELR, s_SysRegData;
    logic [3:0]  s_ESR;

    int test_count = 0;
    int fail_count = 0;

    // Behavioural model: mode flags, saved link/syndrome, total exceptions taken
    bit          m_in_handler;
    bit          m_halted;
    logic [63:0] m_elr;
    logic [3:0]  m_esr;
    int          m_count;
    bit          irq_hist[2];

    exception_ctrl dut (
        .clk(clk), .reset(reset), .PC(PC), .NotAnInstr(NotAnInstr), .ERet(ERet),
        .ExtIRQ(ExtIRQ), .SysRegSel(SysRegSel), .ExcTake(ExcTake), .ExcPC(ExcPC),
        .IrqAck(IrqAck), .Halt(Halt), .ELR(ELR), .ESR(ESR), .SysRegData(SysRegData)
    );

    exception_ctrl #(.CNT_W(2)) dut_small (
        .clk(clk), .reset(reset), .PC(PC), .NotAnInstr(NotAnInstr), .ERet(ERet),
        .ExtIRQ(ExtIRQ), .SysRegSel(SysRegSel), .ExcTake(s_ExcTake), .ExcPC(s_ExcPC),
        .IrqAck(s_IrqAck), .Halt(s_Halt), .ELR(s_ELR), .ESR(s_ESR), .SysRegData(s_SysRegData)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        test_count++;
        if (obs !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_in_handler = 0;
        m_halted     = 0;
        m_elr        = 64'd0;
        m_esr        = 4'd0;
        m_count      = 0;
        irq_hist[0]  = 0;
        irq_hist[1]  = 0;
    endtask

    function automatic logic [3:0] modelCause();
        if (NotAnInstr) return 4'd1;
        if (ERet)       return 4'd3;
        if (irq_hist[1]) return 4'd2;
        return 4'd0;
    endfunction

    function automatic logic [63:0] modelSysReg(input int limit);
        int sat;
        sat = (m_count > limit) ? limit : m_count;
        case (SysRegSel)
            2'b00:   return m_elr;
            2'b01:   return 64'(m_esr);
            2'b10:   return 64'(sat);
            default: return m_halted ? 64'd2 : (m_in_handler ? 64'd1 : 64'd0);
        endcase
    endfunction

    task automatic checkCycle();
        logic        e_take, e_ack;
        logic [63:0] e_pc;
        e_take = 0;
        e_ack  = 0;
        e_pc   = VEC;
        if (reset && !m_halted) begin
            if (!m_in_handler) begin
                e_take = (modelCause() != 4'd0);
                e_ack  = (modelCause() == 4'd2);
            end else if (!NotAnInstr && ERet) begin
                e_take = 1;
                e_pc   = m_elr;
            end
        end
        checkOutput("exc_take", 64'(ExcTake), 64'(e_take));
        checkOutput("exc_pc", ExcPC, e_pc);
        checkOutput("irq_ack", 64'(IrqAck), 64'(e_ack));
        checkOutput("halt", 64'(Halt), 64'(m_halted));
        checkOutput("elr", ELR, m_elr);
        checkOutput("esr", 64'(ESR), 64'(m_esr));
        checkOutput("sysreg", SysRegData, modelSysReg(65535));
        checkOutput("small_sysreg", s_SysRegData, modelSysReg(3));
        checkOutput("small_take", 64'(s_ExcTake), 64'(e_take));
    endtask

    task automatic modelEdge();
        logic [3:0] c;
        c = modelCause();
        if (!m_halted) begin
            if (!m_in_handler) begin
                if (c != 4'd0) begin
                    m_elr        = PC;
                    m_esr        = c;
                    m_count      = m_count + 1;
                    m_in_handler = 1;
                end
            end else if (NotAnInstr) begin
                m_halted = 1;
                m_esr    = 4'd1;
            end else if (ERet) begin
                m_in_handler = 0;
            end
        end
        irq_hist[1] = irq_hist[0];
        irq_hist[0] = ExtIRQ;
    endtask

    // Called just after a rising edge; drives one cycle, checks mid-cycle, advances the model
    task automatic applyStimulus(input logic rst, input logic [63:0] pc, input logic nai,
                                 input logic eret, input logic irq, input logic [1:0] sel);
        reset      = rst;
        PC         = pc;
        NotAnInstr = nai;
        ERet       = eret;
        ExtIRQ     = irq;
        SysRegSel  = sel;
        if (!rst) modelReset();
        @(negedge clk);
        checkCycle();
        @(posedge clk);
        if (reset) modelEdge();
        else       modelReset();
        #1;
    endtask

    initial begin
        int halted_cycles;
        reset = 0; PC = 0; NotAnInstr = 1; ERet = 0; ExtIRQ = 1; SysRegSel = 2'b11;
        modelReset();
        @(posedge clk);
        #1;

        applyStimulus(0, 64'h40, 1, 0, 1, 2'b11);
        applyStimulus(0, 64'h40, 1, 0, 1, 2'b11);
        checkOutput("rst_take_const", 64'(ExcTake), 64'd0);
        checkOutput("rst_status_const", SysRegData, 64'd0);

        applyStimulus(1, 64'h40, 1, 0, 0, 2'b00);
        checkOutput("entry_elr_const", ELR, 64'h40);
        checkOutput("entry_esr_const", 64'(ESR), 64'd1);

        applyStimulus(1, 64'hE0, 0, 1, 0, 2'b11);
        checkOutput("ret_status_const", SysRegData, 64'd0);
        applyStimulus(1, 64'h44, 0, 1, 0, 2'b01);
        checkOutput("eret_run_esr_const", 64'(ESR), 64'd3);
        applyStimulus(1, 64'h50, 0, 1, 0, 2'b00);

        applyStimulus(1, 64'h100, 0, 0, 1, 2'b01);
        applyStimulus(1, 64'h100, 0, 0, 1, 2'b01);
        applyStimulus(1, 64'h100, 0, 0, 1, 2'b01);
        checkOutput("irq_elr_const", ELR, 64'h100);
        checkOutput("irq_esr_const", 64'(ESR), 64'd2);
        repeat (3) applyStimulus(1, 64'h104, 0, 0, 1, 2'b10);

        applyStimulus(1, 64'h108, 0, 1, 1, 2'b00);
        applyStimulus(1, 64'h200, 1, 0, 1, 2'b01);
        checkOutput("prio_esr_const", 64'(ESR), 64'd1);
        applyStimulus(1, 64'h204, 0, 1, 1, 2'b01);
        applyStimulus(1, 64'h300, 0, 0, 1, 2'b01);
        checkOutput("prio_irq_esr_const", 64'(ESR), 64'd2);

        applyStimulus(1, 64'h304, 1, 0, 0, 2'b11);
        checkOutput("fault_elr_const", ELR, 64'h300);
        repeat (3) applyStimulus(1, 64'h308, 0, 1, 1, 2'b10);
        checkOutput("sat_count_const", s_SysRegData, 64'd3);

        // Asynchronous clear of a double fault, observed before any clock edge
        checkOutput("halt_before_clear", 64'(Halt), 64'd1);
        #2 reset = 0;
        modelReset();
        #1;
        checkOutput("halt_async_clear", 64'(Halt), 64'd0);
        applyStimulus(0, 64'h0, 0, 0, 0, 2'b11);

        halted_cycles = 0;
        for (int i = 0; i < 800; i++) begin
            logic rst_v;
            halted_cycles = m_halted ? halted_cycles + 1 : 0;
            rst_v = ($urandom_range(0, 63) != 0) && (halted_cycles < 4);
            applyStimulus(rst_v, {$urandom, $urandom} & ~64'd3,
                          $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
                          ($urandom_range(0, 5) == 0) ? ~ExtIRQ : ExtIRQ,
                          2'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule

// File: doc/exception_ctrl.md
Name: exception_ctrl

Overview:
- Sequential exception/interrupt controller for the single-cycle LEGv8 core.
- Consumes the main decoder's NotAnInstr and ERet flags plus an external interrupt line.
- Redirects the PC to the exception vector and holds ELR/ESR.
- Sequences entry to and return from the handler, and supplies system-register data for MRS.

Parameters:
- EXC_VECTOR, 64'h0000_0000_0000_00D8, PC loaded on exception entry.
- CNT_W, 16, width of the saturating exception counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- PC  in  64  address of the instruction executing this cycle.
- NotAnInstr  in  1  decoder flag, invalid opcode this cycle.
- ERet  in  1  decoder flag, ERET this cycle.
- ExtIRQ  in  1  external interrupt request, asynchronous level.
- SysRegSel  in  2  MRS source: 00 ELR, 01 ESR, 10 count, 11 status.
- ExcTake  out  1  redirect PC to ExcPC; core suppresses RegWrite/MemWrite this cycle.
- ExcPC  out  64  redirect target: EXC_VECTOR on entry, ELR on return.
- IrqAck  out  1  one-cycle pulse when an interrupt is taken.
- Halt  out  1  double fault; core freezes PC.
- ELR  out  64  exception link register.
- ESR  out  4  exception syndrome (cause code).
- SysRegData  out  64  combinational MRS read data.

Behaviour:
- Reset (reset=0, async):
  - Outputs: ELR=0, ESR=0, count=0, state=RUN, synchronizer=00, ExcTake=0, IrqAck=0, Halt=0.
  - ExcPC: equals EXC_VECTOR during reset.
  - Reset mid-handler: aborts to RUN with no ELR restore.
- IRQ synchronizer:
  - 2-flop synchronizer produces irq_s.
  - ExtIRQ rising at edge N is visible as irq_s after edge N+2.
- Cause codes:
  - 4'b0001 invalid opcode.
  - 4'b0010 external IRQ.
  - 4'b0011 ERET outside handler.
- States: RUN, HANDLER, FAULT.
- RUN:
  - Priority: NotAnInstr > ERet (illegal) > irq_s.
  - Any cause present: ExcTake=1 and ExcPC=EXC_VECTOR combinationally in the same cycle.
  - Next edge: ELR<=PC, ESR<=cause, count+=1 (saturates at all ones), state<=HANDLER.
  - IrqAck=1 combinationally only when the cause is IRQ.
  - ELR captures the PC of the suppressed instruction, so ERET re-executes it; the handler must skip invalid instructions by adjusting ELR.
  - No cause: ExcTake=0; state unchanged.
- HANDLER:
  - Interrupts are masked; irq_s is ignored, and IrqAck is never asserted.
  - ERet: ExcTake=1, ExcPC=ELR combinationally; next edge state<=RUN. ELR/ESR are retained for post-mortem MRS.
  - NotAnInstr (with or without ERet): next edge state<=FAULT, ESR<=0001; ELR unchanged; ExcTake=0.
  - Neither flag: hold state.
- FAULT:
  - Halt=1 continuously; ExcTake=0; all inputs ignored until reset.
- SysRegData:
  - 00 ELR.
  - 01 zero-extended ESR.
  - 10 zero-extended count.
  - 11 {62'b0, state encoding} with RUN=00, HANDLER=01, FAULT=10.
  - Value is the register value before the current edge.
- Simultaneous events:
  - NotAnInstr+irq_s in RUN: invalid-opcode cause wins; the IRQ stays pending.
  - After ERET returns, a still-high irq_s is taken on the first RUN cycle. That is one cycle after the ERET edge, and ELR = PC of that cycle.
- Latency:
  - Entry redirect: 0 cycles (combinational).
  - Registered state change: 1 edge.
  - IRQ recognition: 2 edges after ExtIRQ is asserted.

Test Plan:
- Reset: hold reset=0 with NotAnInstr=1 and ExtIRQ=1. Required: ExcTake=0, Halt=0, ELR=0, ESR=0, SysRegData(sel=11)=0. Release reset; NotAnInstr is taken on the first RUN cycle.
- Invalid opcode entry: PC=0x40, NotAnInstr=1 in RUN. Required: ExcTake=1 and ExcPC=0xD8 that cycle; after the edge ELR=0x40, ESR=1, count=1, status=01.
- Return: in HANDLER, set ELR-path PC=0xE0 and ERet=1. Required: ExcTake=1 and ExcPC=0x40; after the edge status=00. Then ERet=1 in RUN requires ESR=3 and ExcPC=0xD8.
- IRQ: raise ExtIRQ at edge 0 with PC=0x100.
  - Required: no ExcTake at edges 0–1; ExcTake=1 and IrqAck=1 for exactly one cycle after edge 2; then ESR=2, ELR=0x100.
  - Keep ExtIRQ high in HANDLER: no second IrqAck until ERET.
- Priority: NotAnInstr=1 and irq_s=1 in RUN together. Required: ESR=1, IrqAck=0. After ERET, the IRQ is taken next cycle with IrqAck=1 and ESR=2.
- Double fault: NotAnInstr=1 in HANDLER. Required: next edge Halt=1, status=10, ELR unchanged. Further ERet or ExtIRQ changes nothing; async reset clears Halt without waiting for a clock edge.
- Counter saturation (CNT_W=2): take 5 exceptions. Required: SysRegData(sel=10)=3.
